// File: rtl/counter_bank_pkg.sv
// Shared step encoding and saturating/wrapping count update for counter_bank.
package counter_bank_pkg;

  localparam int CNT_MAX_W = 32;

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_INC,
    STEP_DEC,
    STEP_CLR
  } ch_step_e;

  typedef struct packed {
    logic                 tc;
    logic [CNT_MAX_W-1:0] count;
  } cnt_res_t;

  // Counts are zero-extended to CNT_MAX_W; max_val is the channel's 2^WIDTH-1.
  function automatic cnt_res_t step_count(input logic [CNT_MAX_W-1:0] cnt,
                                          input logic [CNT_MAX_W-1:0] max_val,
                                          input ch_step_e             step,
                                          input logic                 sat);
    cnt_res_t res;
    res.tc    = 1'b0;
    res.count = cnt;
    unique case (step)
      STEP_CLR: res.count = '0;
      STEP_INC: begin
        if (cnt == max_val) begin
          res.tc    = 1'b1;
          res.count = sat ? max_val : '0;
        end else begin
          res.count = cnt + 32'd1;
        end
      end
      STEP_DEC: begin
        if (cnt == '0) begin
          res.tc    = 1'b1;
          res.count = sat ? '0 : max_val;
        end else begin
          res.count = cnt - 32'd1;
        end
      end
      default: ;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/counter_bank_ch.sv
// One counter channel: step decode, count register, terminal-count and compare pulses.
module counter_bank_ch
  import counter_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             enable,
  input  logic             clear,
  input  logic             up,
  input  logic             down,
  input  logic             auto_cnt,
  input  logic             auto_dn,
  input  logic             sat,
  input  logic [WIDTH-1:0] cmp_value,
  output logic [WIDTH-1:0] count,
  output logic             tc_pulse,
  output logic             cmp_pulse
);

  localparam logic [CNT_MAX_W-1:0] MAX_VAL = CNT_MAX_W'((64'd1 << WIDTH) - 64'd1);

  ch_step_e             step;
  logic [CNT_MAX_W-1:0] cnt_ext;
  cnt_res_t             res;
  logic                 unused_res_hi;
  logic                 eq;
  logic                 eq_q;

  always_comb begin
    step = STEP_HOLD;
    if (clear)               step = STEP_CLR;
    else if (!enable)        step = STEP_HOLD;
    else if (up && down)     step = STEP_HOLD;
    else if (up)             step = STEP_INC;
    else if (down)           step = STEP_DEC;
    else if (auto_cnt && tick) step = auto_dn ? STEP_DEC : STEP_INC;
  end

  always_comb begin
    cnt_ext             = '0;
    cnt_ext[WIDTH-1:0]  = count;
  end

  assign res = step_count(cnt_ext, MAX_VAL, step, sat);

  // Bits above WIDTH are always zero; fold them so they are not left dangling.
  assign unused_res_hi = ^res.count;

  assign eq = (count == cmp_value);

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      count     <= '0;
      tc_pulse  <= 1'b0;
      cmp_pulse <= 1'b0;
      eq_q      <= 1'b1;
    end else begin
      count     <= res.count[WIDTH-1:0];
      tc_pulse  <= res.tc;
      eq_q      <= eq;
      cmp_pulse <= eq && !eq_q;
    end
  end

endmodule

// File: rtl/counter_bank.sv
// Bank of N_CH up/down counters sharing one programmable down-counting prescaler.
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 24
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic [DIV_WIDTH-1:0]  div_load,
  input  logic [N_CH-1:0]       ch_enable,
  input  logic [N_CH-1:0]       ch_clear,
  input  logic [N_CH-1:0]       ch_up,
  input  logic [N_CH-1:0]       ch_down,
  input  logic [N_CH-1:0]       ch_auto,
  input  logic [N_CH-1:0]       ch_auto_dn,
  input  logic [N_CH-1:0]       ch_sat,
  input  logic [N_CH*WIDTH-1:0] cmp_value,
  output logic [N_CH*WIDTH-1:0] count,
  output logic [N_CH-1:0]       tc_pulse,
  output logic [N_CH-1:0]       cmp_pulse,
  output logic                  tick
);

  logic [DIV_WIDTH-1:0] div_cnt;

  // div_load is only sampled at reload, so a new period starts after the current one ends.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == '0) begin
      div_cnt <= div_load;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt - DIV_WIDTH'(1);
      tick    <= 1'b0;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    counter_bank_ch #(
      .WIDTH(WIDTH)
    ) u_ch (
      .sys_clk   (sys_clk),
      .reset     (reset),
      .tick      (tick),
      .enable    (ch_enable[i]),
      .clear     (ch_clear[i]),
      .up        (ch_up[i]),
      .down      (ch_down[i]),
      .auto_cnt  (ch_auto[i]),
      .auto_dn   (ch_auto_dn[i]),
      .sat       (ch_sat[i]),
      .cmp_value (cmp_value[i*WIDTH +: WIDTH]),
      .count     (count[i*WIDTH +: WIDTH]),
      .tc_pulse  (tc_pulse[i]),
      .cmp_pulse (cmp_pulse[i])
    );
  end

endmodule
